// File: rtl/synth_pkg.sv
// Shared constants for the synth operator: command codes, waveform select encoding, phase width.
package synth_pkg;

    localparam int unsigned PHASE_W = 16;

    localparam logic [7:0] CMD_IDLE    = 8'h00;
    localparam logic [7:0] CMD_STEP    = 8'h01;
    localparam logic [7:0] CMD_PUSH    = 8'h81;
    localparam logic [7:0] CMD_FREQ_LO = 8'h41;
    localparam logic [7:0] CMD_FREQ_HI = 8'h11;
    localparam logic [7:0] CMD_AMP     = 8'h51;
    localparam logic [7:0] CMD_WAVE    = 8'h20;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_ZERO   = 2'd3
    } wave_e;

endpackage

// File: rtl/synth_sample_fifo.sv
// DEPTH x 8 first-word-fall-through sample FIFO; pushes while full are dropped,
// pops while empty are ignored.
module synth_sample_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       valid,
    output logic [7:0] dout
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    // Full/empty are judged on the registered count, so a pop cannot make room
    // for a push in the same cycle.
    always_comb begin
        push_ok  = push && (count_q != FULL_CNT);
        pop_ok   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == FULL_CNT);
    assign valid = (count_q != '0);
    assign dout  = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/synth_op.sv
// Synth operator: decodes the control stream, runs the phase accumulator and
// feeds amplitude-scaled samples into the DAC FIFO. Optional SYNTH_OP_OVF_CNT_EN.
module synth_op
    import synth_pkg::*;
#(
    parameter int unsigned          DEPTH      = 16,
    parameter logic [PHASE_W-1:0]   RESET_FREQ = 16'h0100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] synth_ctrl,
    input  logic [7:0] synth_data,
    output logic       fifo_full,
    input  logic       dac_rd,
    output logic       dac_valid,
    output logic [7:0] dac_data,
    output logic [7:0] ovf_cnt
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic [7:0]         amp_q, amp_d;
    wave_e              wave_q, wave_d;
    logic [7:0]         sample_q, sample_d;
    logic [7:0]         wave_val;
    logic               push;

    always_comb begin
        phase_d = phase_q;
        freq_d  = freq_q;
        amp_d   = amp_q;
        wave_d  = wave_q;
        push    = 1'b0;
        case (synth_ctrl)
            CMD_STEP:    phase_d      = phase_q + freq_q;
            CMD_PUSH:    push         = 1'b1;
            CMD_FREQ_LO: freq_d[7:0]  = synth_data;
            CMD_FREQ_HI: freq_d[15:8] = synth_data;
            CMD_AMP:     amp_d        = synth_data;
            CMD_WAVE:    wave_d       = wave_e'(synth_data[1:0]);
            default:     ;
        endcase
    end

    // Sample is built from registered phase/amp, so it trails a command by one extra edge.
    always_comb begin
        wave_val = '0;
        case (wave_q)
            WAVE_SAW:    wave_val = phase_q[15:8];
            WAVE_SQUARE: wave_val = phase_q[15] ? 8'hFF : 8'h00;
            WAVE_TRI:    wave_val = phase_q[15] ? ~phase_q[14:7] : phase_q[14:7];
            default:     wave_val = '0;
        endcase
        sample_d = 8'((16'(wave_val) * 16'(amp_q)) >> 8);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q  <= '0;
            freq_q   <= RESET_FREQ;
            amp_q    <= '0;
            wave_q   <= WAVE_SAW;
            sample_q <= '0;
        end else begin
            phase_q  <= phase_d;
            freq_q   <= freq_d;
            amp_q    <= amp_d;
            wave_q   <= wave_d;
            sample_q <= sample_d;
        end
    end

    synth_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (dac_rd),
        .din     (sample_q),
        .full    (fifo_full),
        .valid   (dac_valid),
        .dout    (dac_data)
    );

`ifdef SYNTH_OP_OVF_CNT_EN
    logic [7:0] ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_synth_op.sv
// Directed self-checking bench for synth_op with hand-computed expected samples.
module tb_synth_op;

    logic       clk;
    logic       reset_n;
    logic [7:0] synth_ctrl;
    logic [7:0] synth_data;
    logic       fifo_full;
    logic       dac_rd;
    logic       dac_valid;
    logic [7:0] dac_data;
    logic [7:0] ovf_cnt;

    int total = 0;
    int bad   = 0;

`ifdef SYNTH_OP_OVF_CNT_EN
    localparam logic [7:0] OVF_ONE = 8'd1;
    localparam logic [7:0] OVF_TWO = 8'd2;
`else
    localparam logic [7:0] OVF_ONE = 8'd0;
    localparam logic [7:0] OVF_TWO = 8'd0;
`endif

    synth_op #(
        .DEPTH      (16),
        .RESET_FREQ (16'h0100)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .synth_ctrl (synth_ctrl),
        .synth_data (synth_data),
        .fifo_full  (fifo_full),
        .dac_rd     (dac_rd),
        .dac_valid  (dac_valid),
        .dac_data   (dac_data),
        .ovf_cnt    (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one command for one clock edge, then sample 1 time unit after the edge.
    task automatic cyc(input logic [7:0] c, input logic [7:0] d, input logic rd);
        synth_ctrl = c;
        synth_data = d;
        dac_rd     = rd;
        @(posedge clk);
        #1;
        synth_ctrl = 8'h00;
        synth_data = 8'h00;
        dac_rd     = 1'b0;
    endtask

    // STEP, settle one edge, then PUSH the stepped sample.
    task automatic step_push();
        cyc(8'h01, 8'h00, 1'b0);
        cyc(8'h00, 8'h00, 1'b0);
        cyc(8'h81, 8'h00, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        synth_ctrl = 8'h00;
        synth_data = 8'h00;
        dac_rd     = 1'b0;
        #12;
        chk("rst_full", {7'd0, fifo_full}, 8'h00);
        chk("rst_valid", {7'd0, dac_valid}, 8'h00);
        chk("rst_data", dac_data, 8'h00);
        chk("rst_ovf", ovf_cnt, 8'h00);
        #5 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // amp=0 after reset -> pushed sample is zero
        cyc(8'h81, 8'h00, 1'b0);
        chk("first_valid", {7'd0, dac_valid}, 8'h01);
        chk("first_data", dac_data, 8'h00);
        cyc(8'h00, 8'h00, 1'b1);
        chk("first_pop", {7'd0, dac_valid}, 8'h00);

        // freq 0x1000, 3 steps -> phase 0x3000, saw 0x30*0xFF>>8 = 0x2F
        cyc(8'h41, 8'h00, 1'b0);
        cyc(8'h11, 8'h10, 1'b0);
        cyc(8'h51, 8'hFF, 1'b0);
        cyc(8'h20, 8'h00, 1'b0);
        cyc(8'h01, 8'h00, 1'b0);
        cyc(8'h01, 8'h00, 1'b0);
        step_push();
        chk("saw_valid", {7'd0, dac_valid}, 8'h01);
        chk("saw_3000", dac_data, 8'h2F);
        cyc(8'h00, 8'h00, 1'b1);

        // 12 more steps -> 0xF000; freq 0x2000 -> 0x1000 (wrap) -> 0x0F
        for (int i = 0; i < 12; i++) cyc(8'h01, 8'h00, 1'b0);
        cyc(8'h11, 8'h20, 1'b0);
        step_push();
        chk("saw_wrap", dac_data, 8'h0F);
        cyc(8'h00, 8'h00, 1'b1);

        // square, amp 0x80: phase 0x8000 -> 0x7F
        cyc(8'h20, 8'h01, 1'b0);
        cyc(8'h51, 8'h80, 1'b0);
        cyc(8'h11, 8'h70, 1'b0);
        step_push();
        // freq 0xFFFF: phase 0x7FFF -> 0x00
        cyc(8'h11, 8'hFF, 1'b0);
        cyc(8'h41, 8'hFF, 1'b0);
        step_push();
        // triangle at 0x7FFF: p[14:7]=0xFF, *0x80 -> 0x7F; unknown codes must not touch amp
        cyc(8'h20, 8'h02, 1'b0);
        cyc(8'h50, 8'h00, 1'b0);
        cyc(8'h52, 8'h00, 1'b0);
        cyc(8'h00, 8'h00, 1'b0);
        cyc(8'h81, 8'h00, 1'b0);
        // waveform 3 -> zero
        cyc(8'h20, 8'h03, 1'b0);
        cyc(8'h00, 8'h00, 1'b0);
        cyc(8'h81, 8'h00, 1'b0);
        chk("sq_8000", dac_data, 8'h7F);
        cyc(8'h00, 8'h00, 1'b1);
        chk("sq_7fff", dac_data, 8'h00);
        cyc(8'h00, 8'h00, 1'b1);
        chk("tri_7fff", dac_data, 8'h7F);
        cyc(8'h00, 8'h00, 1'b1);
        chk("wave3_valid", {7'd0, dac_valid}, 8'h01);
        chk("wave3", dac_data, 8'h00);
        cyc(8'h00, 8'h00, 1'b1);
        chk("drain_empty", {7'd0, dac_valid}, 8'h00);

        // fill: saw, amp 0xFF, freq 0x0100 from 0x7FFF -> samples 0x7F,0x80,...
        cyc(8'h20, 8'h00, 1'b0);
        cyc(8'h51, 8'hFF, 1'b0);
        cyc(8'h11, 8'h01, 1'b0);
        cyc(8'h41, 8'h00, 1'b0);
        for (int i = 0; i < 15; i++) step_push();
        chk("full_at15", {7'd0, fifo_full}, 8'h00);
        step_push();
        chk("full_at16", {7'd0, fifo_full}, 8'h01);
        step_push();
        chk("drop17_full", {7'd0, fifo_full}, 8'h01);
        chk("drop17_ovf", ovf_cnt, OVF_ONE);
        chk("drop17_head", dac_data, 8'h7F);
        // push with pop at full: push dropped, pop accepted
        cyc(8'h81, 8'h00, 1'b1);
        chk("pushpop_full", {7'd0, fifo_full}, 8'h00);
        chk("pushpop_ovf", ovf_cnt, OVF_TWO);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("order_%0d", i), dac_data, 8'(8'h7F + i));
            cyc(8'h00, 8'h00, 1'b1);
        end
        chk("fill_empty", {7'd0, dac_valid}, 8'h00);

        // count 5 then simultaneous push/pop; phase w=0x91.. gives 0x90..0x95
        for (int i = 0; i < 5; i++) step_push();
        cyc(8'h01, 8'h00, 1'b0);
        cyc(8'h00, 8'h00, 1'b0);
        cyc(8'h81, 8'h00, 1'b1);
        for (int i = 1; i < 6; i++) begin
            chk($sformatf("pp5_%0d", i), dac_data, 8'(8'h90 + i));
            cyc(8'h00, 8'h00, 1'b1);
        end
        chk("pp5_empty", {7'd0, dac_valid}, 8'h00);

        // reset mid-burst with a non-default freq loaded
        cyc(8'h11, 8'h33, 1'b0);
        step_push();
        step_push();
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", {7'd0, dac_valid}, 8'h00);
        chk("mid_rst_data", dac_data, 8'h00);
        chk("mid_rst_ovf", ovf_cnt, 8'h00);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        // freq back to 0x0100, phase 0: two steps -> w=0x02 -> 0x01
        cyc(8'h51, 8'hFF, 1'b0);
        cyc(8'h01, 8'h00, 1'b0);
        step_push();
        chk("post_rst_freq", dac_data, 8'h01);
        cyc(8'h00, 8'h00, 1'b1);
        chk("post_rst_empty", {7'd0, dac_valid}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synth_op.md
Name: synth_op

Overview:
- Operator-side responder to the synth control arbiter: decodes the 8-bit synth_ctrl/synth_data command stream, holds operator parameter registers, and advances a 16-bit phase accumulator.
- Generates an amplitude-scaled 8-bit sample and pushes it into an internal sample FIFO on command.
- Reports fifo_full back to the arbiter for back-pressure; the DAC side drains the FIFO.

Parameters:
- DEPTH, 16, sample FIFO depth in entries; power of 2, minimum 2.
- RESET_FREQ, 16'h0100, freq_word value after reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- synth_ctrl  in  8  command code, registered upstream, one code per cycle
- synth_data  in  8  command operand, valid with synth_ctrl
- fifo_full  out  1  sample FIFO holds DEPTH entries
- dac_rd  in  1  pop request from DAC side
- dac_valid  out  1  FIFO non-empty
- dac_data  out  8  FIFO head, first-word-fall-through
- ovf_cnt  out  8  dropped-push counter (see Optional Feature)

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. On reset: phase_acc=0, freq_word=RESET_FREQ, amp=0, wave_sel=0, sample_q=0, FIFO empty, fifo_full=0, dac_valid=0, dac_data=0, ovf_cnt=0.
- Commands are decoded every clk edge on the exact 8-bit value:
  - 0x00 IDLE: no action.
  - 0x01 STEP: phase_acc <= phase_acc + freq_word, mod 2^16, wrap silent.
  - 0x81 PUSH: write sample_q into FIFO.
  - 0x41 FREQ_LO: freq_word[7:0] <= synth_data.
  - 0x11 FREQ_HI: freq_word[15:8] <= synth_data.
  - 0x51 AMP: amp <= synth_data.
  - 0x20 WAVE: wave_sel <= synth_data[1:0].
  - Any other value: ignored, no state change.
- Waveform w (8 bit), from p = phase_acc:
  - sel 0 saw: w = p[15:8].
  - sel 1 square: w = p[15] ? 8'hFF : 8'h00.
  - sel 2 triangle: w = p[15] ? ~p[14:7] : p[14:7].
  - sel 3: w = 0.
- Sample: sample_q <= (w*amp)>>8 (16-bit product, upper byte), registered every cycle. sample_q reflects a register update 2 edges after the command edge. The arbiter guarantees at least 2 cycles between STEP and PUSH, so a PUSH sees the stepped phase.
- FIFO:
  - PUSH with count<DEPTH: entry written.
  - PUSH with count==DEPTH: dropped, even if dac_rd is also high that cycle (full judged on registered count).
  - dac_rd with count==0: ignored.
  - Simultaneous accepted push and pop: count unchanged.
  - fifo_full = (count==DEPTH) and dac_valid = (count!=0), both registered from count with no extra latency.
  - Pointers wrap modulo DEPTH.
- Reset mid-operation: FIFO contents discarded, all registers return to reset values immediately.

Optional Feature:
- Macro SYNTH_OP_OVF_CNT_EN.
- Defined: ovf_cnt increments on each dropped PUSH and saturates at 8'hFF.
- Undefined: counter logic omitted; ovf_cnt tied to 8'h00.

Decomposition:
- Package synth_pkg: command code constants (CMD_IDLE, CMD_STEP, CMD_PUSH, CMD_FREQ_LO, CMD_FREQ_HI, CMD_AMP, CMD_WAVE), wave_sel encoding constants, PHASE_W=16.
- Sub-module synth_sample_fifo: DEPTH x 8 FWFT FIFO with full/empty/count and drop-on-full.

Test Plan:
- Reset → fifo_full=0, dac_valid=0, dac_data=0, ovf_cnt=0; first PUSH yields 0x00 (amp=0).
- FREQ_LO 0x00, FREQ_HI 0x10, AMP 0xFF, WAVE 0; 3×STEP; PUSH → dac_valid=1, dac_data=0x2F (0x30*0xFF>>8).
- freq 0x2000 from phase 0xF000; STEP → phase 0x1000. Saw, amp 0xFF, PUSH → 0x0F.
- WAVE 1, AMP 0x80, phase 0x8000; PUSH → 0x7F. Phase 0x7FFF → 0x00.
- 16 PUSHes without dac_rd → fifo_full=1 after 16th; 17th dropped, ovf_cnt=1 (0 without macro); one dac_rd → fifo_full=0 next cycle, order preserved.
- Push/pop same cycle at count 5 → count stays 5, FIFO order intact; reset_n low mid-burst → FIFO empty, freq_word=0x0100 immediately.
